// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_pkg
//  Brief    : Shared FSM state and owner encodings for the memory arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE    = 2'd0;
    localparam logic [1:0] ARB_WAIT_IF = 2'd1;
    localparam logic [1:0] ARB_WAIT_EX = 2'd2;

    localparam logic ARB_OWNER_IF = 1'b0;
    localparam logic ARB_OWNER_EX = 1'b1;

    // Width needed to hold a streak count of 0..max inclusive.
    function automatic int streak_width(input int max_streak);
        return (max_streak < 1) ? 1 : $clog2(max_streak + 1);
    endfunction

endpackage : mem_arbiter_pkg
`default_nettype wire

// File: rtl/mem_arb_prio.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_prio
//  Brief    : Owner selection (data-side priority) and the EX streak counter
//             that forces a fetch grant after too many back-to-back EX grants.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arb_prio
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_EX_STREAK = 4,
    parameter int STREAK_W      = streak_width(MAX_EX_STREAK)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_arb_idle,
    input  logic i_if_req,
    input  logic i_ex_req,
    input  logic i_mem_gnt,
    output logic o_sel_if,
    output logic o_sel_ex
);

    localparam logic [STREAK_W-1:0] c_STREAK_MAX = STREAK_W'(MAX_EX_STREAK);

    logic [STREAK_W-1:0] r_streak;
    logic                w_if_forced;
    logic                w_ex_hs;
    logic                w_if_hs;

    assign w_if_forced = i_if_req && (r_streak == c_STREAK_MAX);

    // Selection is only meaningful while the port is free.
    always_comb begin
        o_sel_ex = 1'b0;
        o_sel_if = 1'b0;
        if (i_arb_idle) begin
            o_sel_ex = i_ex_req && !w_if_forced;
            o_sel_if = i_if_req && !o_sel_ex;
        end
    end

    assign w_ex_hs = o_sel_ex && i_mem_gnt;
    assign w_if_hs = o_sel_if && i_mem_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_streak <= '0;
        end else if (w_ex_hs && i_if_req) begin
            if (r_streak != c_STREAK_MAX) begin
                r_streak <= r_streak + STREAK_W'(1);
            end
        end else if (w_ex_hs || w_if_hs) begin
            r_streak <= '0;
        end
    end

endmodule : mem_arb_prio
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Brief    : Single-outstanding arbiter for the shared memory port between
//             fetch (IF) and load/store (EX); drives the pipeline hold flag.
//             Optional stall counters enabled by MEM_ARB_PERF_CNT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_EX_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,

    input  logic              ex_req_i,
    input  logic              ex_we_i,
    input  logic [ADDR_W-1:0] ex_addr_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    output logic              ex_gnt_o,
    output logic              ex_rvalid_o,
    output logic [DATA_W-1:0] ex_rdata_o,

    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,

    output logic              hold_flag_o
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]       if_stall_cnt_o,
    output logic [31:0]       ex_stall_cnt_o
`endif
);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       w_idle;
    logic       w_sel_if;
    logic       w_sel_ex;
    logic       w_owner;
    logic       w_if_hs;
    logic       w_ex_hs;
    logic       w_rsp_if;
    logic       w_rsp_ex;

    assign w_idle = (r_state == ARB_IDLE);

    mem_arb_prio #(
        .MAX_EX_STREAK (MAX_EX_STREAK)
    ) u_prio (
        .clk        (clk),
        .rst        (rst),
        .i_arb_idle (w_idle),
        .i_if_req   (if_req_i),
        .i_ex_req   (ex_req_i),
        .i_mem_gnt  (mem_gnt_i),
        .o_sel_if   (w_sel_if),
        .o_sel_ex   (w_sel_ex)
    );

    assign w_owner = w_sel_ex ? ARB_OWNER_EX : ARB_OWNER_IF;
    assign w_if_hs = w_sel_if && mem_gnt_i;
    assign w_ex_hs = w_sel_ex && mem_gnt_i;

    // Request side: port follows the selected requester, zeros otherwise.
    always_comb begin
        mem_req_o   = w_sel_if || w_sel_ex;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (w_sel_if || w_sel_ex) begin
            if (w_owner == ARB_OWNER_EX) begin
                mem_we_o    = ex_we_i;
                mem_addr_o  = ex_addr_i;
                mem_wdata_o = ex_wdata_i;
            end else begin
                mem_addr_o  = if_addr_i;
            end
        end
    end

    assign if_gnt_o = w_if_hs;
    assign ex_gnt_o = w_ex_hs;

    // Response side: a response is routed only to the side that owns the
    // outstanding transaction; anything arriving in IDLE is dropped.
    assign w_rsp_if    = (r_state == ARB_WAIT_IF) && mem_rvalid_i;
    assign w_rsp_ex    = (r_state == ARB_WAIT_EX) && mem_rvalid_i;
    assign if_rvalid_o = w_rsp_if;
    assign ex_rvalid_o = w_rsp_ex;
    assign if_rdata_o  = w_rsp_if ? mem_rdata_i : '0;
    assign ex_rdata_o  = w_rsp_ex ? mem_rdata_i : '0;

    assign hold_flag_o = (ex_req_i && !w_ex_hs) ||
                         ((r_state == ARB_WAIT_EX) && !mem_rvalid_i);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_ex_hs) begin
                    w_state_nxt = ARB_WAIT_EX;
                end else if (w_if_hs) begin
                    w_state_nxt = ARB_WAIT_IF;
                end
            end
            ARB_WAIT_IF,
            ARB_WAIT_EX: begin
                if (mem_rvalid_i) begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] r_if_stall_cnt;
    logic [31:0] r_ex_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_stall_cnt <= '0;
            r_ex_stall_cnt <= '0;
        end else begin
            if (if_req_i && !w_if_hs) begin
                r_if_stall_cnt <= r_if_stall_cnt + 32'd1;
            end
            if (ex_req_i && !w_ex_hs) begin
                r_ex_stall_cnt <= r_ex_stall_cnt + 32'd1;
            end
        end
    end

    assign if_stall_cnt_o = r_if_stall_cnt;
    assign ex_stall_cnt_o = r_ex_stall_cnt;
`endif

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Brief    : Directed self-checking bench for mem_arbiter with a response
//             scoreboard; covers stall counters when MEM_ARB_PERF_CNT_EN is set.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int ADDR_W        = 32;
    localparam int DATA_W        = 32;
    localparam int MAX_EX_STREAK = 4;

    logic              clk;
    logic              rst;
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [DATA_W-1:0] if_rdata_o;
    logic              ex_req_i;
    logic              ex_we_i;
    logic [ADDR_W-1:0] ex_addr_i;
    logic [DATA_W-1:0] ex_wdata_i;
    logic              ex_gnt_o;
    logic              ex_rvalid_o;
    logic [DATA_W-1:0] ex_rdata_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              hold_flag_o;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0]       if_stall_cnt_o;
    logic [31:0]       ex_stall_cnt_o;
`endif

    mem_arbiter #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .MAX_EX_STREAK (MAX_EX_STREAK)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .if_gnt_o     (if_gnt_o),
        .if_rvalid_o  (if_rvalid_o),
        .if_rdata_o   (if_rdata_o),
        .ex_req_i     (ex_req_i),
        .ex_we_i      (ex_we_i),
        .ex_addr_i    (ex_addr_i),
        .ex_wdata_i   (ex_wdata_i),
        .ex_gnt_o     (ex_gnt_o),
        .ex_rvalid_o  (ex_rvalid_o),
        .ex_rdata_o   (ex_rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .hold_flag_o  (hold_flag_o)
`ifdef MEM_ARB_PERF_CNT_EN
        ,
        .if_stall_cnt_o (if_stall_cnt_o),
        .ex_stall_cnt_o (ex_stall_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_ex;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   sm;
    logic exp_ex;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        if_req_i     = 1'b0;
        if_addr_i    = '0;
        ex_req_i     = 1'b0;
        ex_we_i      = 1'b0;
        ex_addr_i    = '0;
        ex_wdata_i   = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
    endtask

    // Grant cycle: port must carry the expected owner's request.
    task automatic grant_check(input string tag, input logic is_ex,
                               input logic [31:0] rsp_data, input logic exp_hold);
        exp_t e;
        settle();
        chk({tag, "_memreq"}, 32'(mem_req_o), 32'd1);
        chk({tag, "_ifgnt"},  32'(if_gnt_o),  32'(!is_ex));
        chk({tag, "_exgnt"},  32'(ex_gnt_o),  32'(is_ex));
        chk({tag, "_addr"},   mem_addr_o, is_ex ? ex_addr_i : if_addr_i);
        chk({tag, "_we"},     32'(mem_we_o), is_ex ? 32'(ex_we_i) : 32'd0);
        chk({tag, "_wdata"},  mem_wdata_o, is_ex ? ex_wdata_i : 32'd0);
        chk({tag, "_hold"},   32'(hold_flag_o), 32'(exp_hold));
        e.is_ex = is_ex;
        e.data  = rsp_data;
        sb.push_back(e);
    endtask

    task automatic check_resp(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk({tag, "_rvalid"}, e.is_ex ? 32'(ex_rvalid_o) : 32'(if_rvalid_o), 32'd1);
        chk({tag, "_rdata"},  e.is_ex ? ex_rdata_o : if_rdata_o, e.data);
        chk({tag, "_other_rvalid"}, e.is_ex ? 32'(if_rvalid_o) : 32'(ex_rvalid_o), 32'd0);
    endtask

    // Response phase: optional idle wait cycles, then one rvalid cycle.
    task automatic txn_response(input string tag, input logic is_ex, input int wait_cycles,
                                input logic [31:0] d, input logic drop_if, input logic drop_ex);
        next_cycle();
        if (drop_if) if_req_i = 1'b0;
        if (drop_ex) ex_req_i = 1'b0;
        for (int i = 0; i < wait_cycles; i++) begin
            settle();
            chk({tag, "_wait_req_gnt"}, 32'({mem_req_o, if_gnt_o, ex_gnt_o}), 32'd0);
            chk({tag, "_wait_rvalid"}, 32'({if_rvalid_o, ex_rvalid_o}), 32'd0);
            chk({tag, "_wait_hold"}, 32'(hold_flag_o), 32'(ex_req_i || is_ex));
            next_cycle();
        end
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = d;
        settle();
        check_resp(tag);
        chk({tag, "_rsp_req_gnt"}, 32'({mem_req_o, if_gnt_o, ex_gnt_o}), 32'd0);
        chk({tag, "_rsp_hold"}, 32'(hold_flag_o), 32'(ex_req_i));
        next_cycle();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
    endtask

    // Requester protocol: a pending (ungranted) request must stay asserted.
    logic prev_if_pend = 1'b0;
    logic prev_ex_pend = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            assert (!(prev_if_pend && !if_req_i)) else begin
                errors++;
                $error("FAIL if_req_protocol observed=0 expected=1");
            end
            assert (!(prev_ex_pend && !ex_req_i)) else begin
                errors++;
                $error("FAIL ex_req_protocol observed=0 expected=1");
            end
        end
        prev_if_pend = !rst && if_req_i && !if_gnt_o;
        prev_ex_pend = !rst && ex_req_i && !ex_gnt_o;
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        settle();
        chk("rst_state",  32'(dut.r_state), 32'd0);
        chk("rst_streak", 32'(dut.u_prio.r_streak), 32'd0);
        chk("rst_outs", 32'({mem_req_o, mem_we_o, if_gnt_o, ex_gnt_o, if_rvalid_o,
                             ex_rvalid_o, hold_flag_o}), 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
`ifdef MEM_ARB_PERF_CNT_EN
        chk("rst_if_cnt", if_stall_cnt_o, 32'd0);
        chk("rst_ex_cnt", ex_stall_cnt_o, 32'd0);
`endif
        next_cycle();

        // IF-only fetch
        if_req_i  = 1'b1;
        if_addr_i = 32'h0000_0100;
        mem_gnt_i = 1'b1;
        grant_check("if_only", 1'b0, 32'hDEAD_BEEF, 1'b0);
        txn_response("if_only", 1'b0, 0, 32'hDEAD_BEEF, 1'b1, 1'b0);
        settle();
        chk("if_only_idle", 32'(dut.r_state), 32'd0);
        chk("if_only_quiet", 32'({if_rvalid_o, hold_flag_o, mem_req_o}), 32'd0);
        next_cycle();

        // Simultaneous requests: EX first, IF in the following idle cycle
        if_req_i  = 1'b1;
        if_addr_i = 32'h0000_0200;
        ex_req_i  = 1'b1;
        ex_we_i   = 1'b0;
        ex_addr_i = 32'h0000_2000;
        mem_gnt_i = 1'b1;
        grant_check("simul_ex", 1'b1, 32'h1234_5678, 1'b0);
        txn_response("simul_ex", 1'b1, 1, 32'h1234_5678, 1'b0, 1'b1);
        grant_check("simul_if", 1'b0, 32'hCAFE_F00D, 1'b0);
        txn_response("simul_if", 1'b0, 0, 32'hCAFE_F00D, 1'b1, 1'b0);

        // Starvation guard: four EX grants, one forced IF grant, EX resumes
        sm        = 0;
        if_req_i  = 1'b1;
        if_addr_i = 32'h0000_0300;
        ex_req_i  = 1'b1;
        ex_addr_i = 32'h0000_4000;
        mem_gnt_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_ex = (sm != MAX_EX_STREAK);
            chk($sformatf("starve%0d_streak", i), 32'(dut.u_prio.r_streak), 32'(sm));
            grant_check($sformatf("starve%0d", i), exp_ex, 32'h0000_1000 + 32'(i), !exp_ex);
            sm = exp_ex ? ((sm < MAX_EX_STREAK) ? sm + 1 : sm) : 0;
            txn_response($sformatf("starve%0d", i), exp_ex, 0, 32'h0000_1000 + 32'(i),
                         1'b0, i == 5);
        end
        chk("starve_streak_after", 32'(dut.u_prio.r_streak), 32'(sm));
        grant_check("starve_tail", 1'b0, 32'h0000_2222, 1'b0);
        txn_response("starve_tail", 1'b0, 0, 32'h0000_2222, 1'b1, 1'b0);
        chk("starve_tail_streak", 32'(dut.u_prio.r_streak), 32'd0);

        // Store with one blocked cycle, then ack
        ex_req_i   = 1'b1;
        ex_we_i    = 1'b1;
        ex_addr_i  = 32'h0000_3004;
        ex_wdata_i = 32'h0000_55AA;
        mem_gnt_i  = 1'b0;
        settle();
        chk("store_blocked_gnt",  32'(ex_gnt_o), 32'd0);
        chk("store_blocked_hold", 32'(hold_flag_o), 32'd1);
        chk("store_blocked_req",  32'({mem_req_o, mem_we_o}), 32'b11);
        next_cycle();
        mem_gnt_i = 1'b1;
        grant_check("store", 1'b1, 32'h0000_0A5A, 1'b0);
        txn_response("store", 1'b1, 1, 32'h0000_0A5A, 1'b0, 1'b1);
        ex_we_i    = 1'b0;
        ex_wdata_i = '0;

        // Reset while a load is outstanding; stale response must be dropped
        ex_req_i  = 1'b1;
        ex_addr_i = 32'h0000_5000;
        mem_gnt_i = 1'b1;
        settle();
        chk("rstmid_gnt", 32'(ex_gnt_o), 32'd1);
        next_cycle();
        ex_req_i  = 1'b0;
        mem_gnt_i = 1'b0;
        settle();
        chk("rstmid_wait_state", 32'(dut.r_state), 32'd2);
        rst = 1'b1;
        next_cycle();
        rst          = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hBAD0_BAD0;
        settle();
        chk("rstmid_rvalid", 32'({if_rvalid_o, ex_rvalid_o}), 32'd0);
        chk("rstmid_if_rdata", if_rdata_o, 32'd0);
        chk("rstmid_ex_rdata", ex_rdata_o, 32'd0);
        chk("rstmid_state", 32'(dut.r_state), 32'd0);
        chk("rstmid_streak", 32'(dut.u_prio.r_streak), 32'd0);
        chk("rstmid_outs", 32'({mem_req_o, mem_we_o, if_gnt_o, ex_gnt_o, hold_flag_o}), 32'd0);
        chk("rstmid_addr", mem_addr_o, 32'd0);
        next_cycle();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        next_cycle();

        // IF blocked for five cycles, then granted
        if_req_i  = 1'b1;
        if_addr_i = 32'h0000_0600;
        mem_gnt_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk($sformatf("ifblk%0d_gnt", i), 32'({if_gnt_o, hold_flag_o}), 32'd0);
            next_cycle();
        end
`ifdef MEM_ARB_PERF_CNT_EN
        chk("perf_if_cnt5", if_stall_cnt_o, 32'd5);
        chk("perf_ex_cnt0", ex_stall_cnt_o, 32'd0);
`endif
        mem_gnt_i = 1'b1;
        grant_check("ifblk_grant", 1'b0, 32'h0BAD_CAFE, 1'b0);
        txn_response("ifblk_grant", 1'b0, 0, 32'h0BAD_CAFE, 1'b1, 1'b0);
`ifdef MEM_ARB_PERF_CNT_EN
        chk("perf_if_cnt_hold", if_stall_cnt_o, 32'd5);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        settle();
        chk("perf_if_cnt_rst", if_stall_cnt_o, 32'd0);
        chk("perf_ex_cnt_rst", ex_stall_cnt_o, 32'd0);
`endif
        next_cycle();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single shared memory port between the instruction-fetch requester (IFU) and the load/store requester (EXU).
- Allows one outstanding transaction at a time.
- Uses data-side priority, with a starvation guard for fetch.
- Generates the pipeline hold flag consumed by ctrl. Sits between ifu/exu_top and mems in cpu_top.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_EX_STREAK, 4, max consecutive EX grants while IF is waiting before IF is forced a grant (≥1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
if_req_i  in  1  fetch request; held until if_gnt_o
if_addr_i  in  ADDR_W  fetch address
if_gnt_o  out  1  fetch request accepted this cycle
if_rvalid_o  out  1  fetch data valid (one-cycle pulse)
if_rdata_o  out  DATA_W  fetch data
ex_req_i  in  1  load/store request; held until ex_gnt_o
ex_we_i  in  1  1=store, 0=load
ex_addr_i  in  ADDR_W  data address
ex_wdata_i  in  DATA_W  store data
ex_gnt_o  out  1  data request accepted
ex_rvalid_o  out  1  load data / store ack (one-cycle pulse)
ex_rdata_o  out  DATA_W  load data
mem_req_o  out  1  request to mems
mem_we_o  out  1  write enable to mems
mem_addr_o  out  ADDR_W  address to mems
mem_wdata_o  out  DATA_W  write data to mems
mem_gnt_i  in  1  mems accepted request
mem_rvalid_i  in  1  mems response valid (reads and writes)
mem_rdata_i  in  DATA_W  mems read data
hold_flag_o  out  1  stall request to ctrl

Behaviour:
- Clocking: one clock `clk`; synchronous active-high reset `rst`.
- FSM states: IDLE, WAIT_IF, WAIT_EX. Reset → IDLE, streak counter = 0. All registered outputs reset to 0.
- IDLE, owner selection (combinational): EX wins if ex_req_i is set and NOT (if_req_i && streak == MAX_EX_STREAK); otherwise IF wins if if_req_i is set.
- IDLE, port drive: mem_req_o/we/addr/wdata follow the selected requester. IF owner drives mem_we_o = 0 and mem_wdata_o = 0.
- IDLE, grant: the owner's gnt = mem_gnt_i; the other requester's gnt = 0. Handshake = mem_req_o && mem_gnt_i.
- IDLE → WAIT_EX on an EX handshake. IDLE → WAIT_IF on an IF handshake. No handshake: stay in IDLE.
- Streak counter:
  - EX handshake while if_req_i = 1: streak += 1, saturating at MAX_EX_STREAK.
  - IF handshake, or any EX handshake with if_req_i = 0: streak cleared.
- WAIT_x: mem_req_o = 0 and both gnt = 0. On mem_rvalid_i, the owner's rvalid_o pulses for one cycle with rdata = mem_rdata_i (same cycle, combinational pass-through), then → IDLE.
- Throughput: the next request is issued no earlier than the cycle after the response. Minimum 2 cycles per transaction.
- Non-owner outputs: rvalid = 0 and rdata = 0.
- mem_rvalid_i in IDLE: ignored, which covers a stale response after reset.
- hold_flag_o = (ex_req_i && !ex_gnt_o) || (state == WAIT_EX && !mem_rvalid_i). Fetch stalls are absorbed by the IFU and do not raise hold.
- Simultaneous if_req_i and ex_req_i with streak < MAX: EX is granted; IF keeps its request asserted.
- Reset mid-transaction: FSM returns to IDLE and the outstanding transaction is dropped with no rvalid to either side.
- Requester protocol: a requester dropping its req before gnt is a protocol violation (assertion in the bench only).

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- When defined: adds output ports `if_stall_cnt_o[31:0]` and `ex_stall_cnt_o[31:0]`.
  - Each counts cycles where that side's req = 1 and gnt = 0. Counts wrap at 2^32. Reset clears both to 0.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared defines file (defines.v): FSM state encodings (ARB_IDLE = 2'd0, ARB_WAIT_IF = 2'd1, ARB_WAIT_EX = 2'd2) and the owner encoding (ARB_OWNER_IF / ARB_OWNER_EX).
- One natural sub-module: mem_arb_prio — combinational owner selection plus the streak counter register, outputting sel_ex/sel_if.
- The FSM and output muxing stay in mem_arbiter.

Test Plan:
- IF-only path:
  - Stimulus: if_req = 1, addr 0x100; mems gnt immediately, rvalid 1 cycle later with 0xDEADBEEF.
  - Required: if_gnt pulses in cycle 0, if_rvalid in cycle 1 with 0xDEADBEEF, hold_flag_o = 0 throughout.
- Simultaneous requests:
  - Stimulus: if_req and ex_req (load 0x2000) in the same cycle.
  - Required: ex_gnt first; hold_flag_o = 1 until ex_rvalid; IF is granted in the following IDLE cycle.
- Starvation guard:
  - Stimulus: ex_req held continuously with if_req = 1, MAX_EX_STREAK = 4.
  - Required: exactly 4 EX grants, then 1 IF grant, then EX resumes; streak returns to 0.
- Store ack:
  - Stimulus: ex_we = 1, addr 0x3004, wdata 0x55AA.
  - Required: mem_we_o = 1 with matching addr/data; ex_rvalid pulses; hold drops in the rvalid cycle.
- Reset mid-op:
  - Stimulus: rst in WAIT_EX; mem_rvalid_i arrives 1 cycle after reset.
  - Required: no ex_rvalid_o and no if_rvalid_o; state IDLE; all outputs 0.
- Perf counters (MEM_ARB_PERF_CNT_EN):
  - Stimulus: IF blocked for 5 cycles.
  - Required: if_stall_cnt_o = 5; reset clears it to 0.
